frame_bank_sched: RTL

//  Ping-pong scheduler for two BRAM frame banks shared by the capture writer and the BRAM-to-FIFO reader.
//  - Tracks each bank's state and steers the writer to a free bank.
//  - Starts the reader on the oldest complete frame.
//  - Writer and reader never touch the same bank; frames are dropped instead of torn.

---
 rtl/frame_bank_sched_if.sv | 28 ++
 rtl/frame_bank_sched.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/frame_bank_sched_if.sv
// Handshake bundle between the bank scheduler and the capture writer / BRAM reader.
// master = scheduler side, slave = writer/reader side.
interface frame_bank_sched_if #(
   parameter int BRAM_DEPTH = 16384
);
   localparam int AW = $clog2(BRAM_DEPTH) + 1;

   logic          i_wr_done;
   logic          o_wr_bank;
   logic          i_rd_done;
   logic          o_rd_req;
   logic          o_rd_bank;
   logic [AW-1:0] o_rd_base;
   logic          o_rd_busy;
   logic [15:0]   o_drop_cnt;

   modport master (
      input  i_wr_done, i_rd_done,
      output o_wr_bank, o_rd_req, o_rd_bank,
      output o_rd_base, o_rd_busy, o_drop_cnt
   );

   modport slave (
      output i_wr_done, i_rd_done,
      input  o_wr_bank, o_rd_req, o_rd_bank,
      input  o_rd_base, o_rd_busy, o_drop_cnt
   );
endinterface

// File: rtl/frame_bank_sched.sv
// Ping-pong scheduler for two BRAM frame banks: writer/reader never share a bank.
// Optional FRAME_DROP_CNT_EN adds a saturating dropped-frame counter.
module frame_bank_sched #(
   parameter int BRAM_DEPTH = 16384,
   parameter int REQ_HOLD   = 4
) (
   input logic                i_clk,
   input logic                i_rst,
   frame_bank_sched_if.master bus
);
   localparam int AW = $clog2(BRAM_DEPTH) + 1;
   localparam int CW = (REQ_HOLD > 1) ? $clog2(REQ_HOLD) : 1;

   typedef enum logic [1:0] {BK_EMPTY, BK_FULL, BK_READING} bank_e;
   typedef enum logic [1:0] {RD_IDLE, RD_REQ, RD_BUSY} rd_e;

   bank_e         st_q [2];
   bank_e         st_d [2];
   rd_e           fsm_q, fsm_d;
   logic          wr_q, wr_d;
   logic          rb_q, rb_d;
   logic          req_q, req_d;
   logic          busy_q, busy_d;
   logic [AW-1:0] base_q, base_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rd_ack;
   logic          drop_ev;
   logic          ob;
   logic          sb;

   // Next state: rd_done, then wr_done, then the idle start check.
   always_comb begin
      st_d    = st_q;
      fsm_d   = fsm_q;
      wr_d    = wr_q;
      rb_d    = rb_q;
      req_d   = req_q;
      busy_d  = busy_q;
      cnt_d   = cnt_q;
      drop_ev = 1'b0;
      ob      = ~wr_q;
      sb      = (st_q[1] == BK_FULL);
      rd_ack  = bus.i_rd_done && (fsm_q != RD_IDLE);

      if (rd_ack) begin
         st_d[rb_q] = BK_EMPTY;
         fsm_d      = RD_IDLE;
         req_d      = 1'b0;
         busy_d     = 1'b0;
      end

      if (bus.i_wr_done) begin
         unique case (st_d[ob])
            BK_EMPTY: begin
               st_d[wr_q] = BK_FULL;
               wr_d       = ob;
            end
            BK_FULL: begin
               st_d[wr_q] = BK_FULL;
               st_d[ob]   = BK_EMPTY;
               wr_d       = ob;
               drop_ev    = 1'b1;
            end
            default: drop_ev = 1'b1;
         endcase
      end

      // A bank emptied by a same-cycle drop must not be started;
      // the newer frame is picked up on the next cycle instead.
      if (!rd_ack) begin
         unique case (fsm_q)
            RD_IDLE: begin
               if (st_q[sb] == BK_FULL && st_d[sb] == BK_FULL) begin
                  st_d[sb] = BK_READING;
                  rb_d     = sb;
                  req_d    = 1'b1;
                  busy_d   = 1'b1;
                  cnt_d    = '0;
                  fsm_d    = RD_REQ;
               end
            end
            RD_REQ: begin
               if (cnt_q == CW'(REQ_HOLD - 1)) begin
                  req_d = 1'b0;
                  fsm_d = RD_BUSY;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end

      base_d = rb_d ? AW'(BRAM_DEPTH) : '0;
   end

   // State register with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         st_q[0] <= BK_EMPTY;
         st_q[1] <= BK_EMPTY;
         fsm_q   <= RD_IDLE;
         wr_q    <= 1'b0;
         rb_q    <= 1'b1;
         base_q  <= AW'(BRAM_DEPTH);
         req_q   <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         st_q[0] <= st_d[0];
         st_q[1] <= st_d[1];
         fsm_q   <= fsm_d;
         wr_q    <= wr_d;
         rb_q    <= rb_d;
         base_q  <= base_d;
         req_q   <= req_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.o_wr_bank = wr_q;
   assign bus.o_rd_req  = req_q;
   assign bus.o_rd_bank = rb_q;
   assign bus.o_rd_base = base_q;
   assign bus.o_rd_busy = busy_q;

`ifdef FRAME_DROP_CNT_EN
   logic [15:0] drop_q;

   // Saturating dropped-frame counter, cleared only by reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         drop_q <= '0;
      end else if (drop_ev && drop_q != 16'hFFFF) begin
         drop_q <= drop_q + 16'd1;
      end
   end

   assign bus.o_drop_cnt = drop_q;
`else
   logic unused_drop_ev;
   assign unused_drop_ev = drop_ev;
   assign bus.o_drop_cnt = 16'd0;
`endif
endmodule
